// File: rtl/register_file_if.sv
// Register-file port bundle: write port, two read indices, read data and
// the latched A/B operands.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Read_Reg1;
  logic [ADDR_WIDTH-1:0] Read_Reg2;
  logic [ADDR_WIDTH-1:0] Write_Reg;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic [DATA_WIDTH-1:0] Read_Data1;
  logic [DATA_WIDTH-1:0] Read_Data2;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;

  modport master (
    output RegWrite, Read_Reg1, Read_Reg2, Write_Reg, Write_Data,
    input  Read_Data1, Read_Data2, A, B
  );

  modport slave (
    input  RegWrite, Read_Reg1, Read_Reg2, Write_Reg, Write_Data,
    output Read_Data1, Read_Data2, A, B
  );
endinterface

// File: rtl/register_file.sv
// Multi-cycle MIPS register file: $0 hardwired to zero, two async read ports,
// A/B operand latches. REG_FILE_BYPASS_EN forwards same-edge writes into A/B.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  register_file_if.slave rf
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ridx;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdat;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] opnd_d;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] opnd_q;
  logic                              wr_en;

  assign wr_en = rf.RegWrite && (rf.Write_Reg != '0);
  assign ridx  = {rf.Read_Reg2, rf.Read_Reg1};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      regs <= '0;
    else if (wr_en) regs[rf.Write_Reg] <= rf.Write_Data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rdat[p] = (ridx[p] == '0) ? '0 : regs[ridx[p]];
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes $0, so index 0 is never forwarded
    assign opnd_d[p] = (wr_en && (rf.Write_Reg == ridx[p])) ? rf.Write_Data : rdat[p];
`else
    assign opnd_d[p] = rdat[p];
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) opnd_q <= '0;
    else       opnd_q <= opnd_d;
  end

  assign rf.Read_Data1 = rdat[0];
  assign rf.Read_Data2 = rdat[1];
  assign rf.A          = opnd_q[0];
  assign rf.B          = opnd_q[1];
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expectations are queued per cycle and
// popped against RD1/RD2/A/B after each edge. Honours REG_FILE_BYPASS_EN.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .rf   (bus)
  );

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] mdl[32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [31:0] exp);
    sb_t e;
    e.sel = sel; e.tag = tag; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        0:       obs = bus.Read_Data1;
        1:       obs = bus.Read_Data2;
        2:       obs = bus.A;
        default: obs = bus.B;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : mdl[idx];
  endfunction

  task automatic push_all(input string tag, input logic [31:0] v);
    push(0, {tag, ".rd1"}, v); push(1, {tag, ".rd2"}, v);
    push(2, {tag, ".a"}, v);   push(3, {tag, ".b"}, v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite = we; bus.Write_Reg = wr; bus.Write_Data = wd;
    bus.Read_Reg1 = r1; bus.Read_Reg2 = r2;
  endtask

  // One clock: queue A/B from pre-edge state, update model, queue read ports.
  task automatic cycle(input string tag);
    logic [31:0] ea, eb;
    ea = mrd(bus.Read_Reg1);
    eb = mrd(bus.Read_Reg2);
`ifdef REG_FILE_BYPASS_EN
    if (bus.RegWrite && bus.Write_Reg != 0 && bus.Write_Reg == bus.Read_Reg1) ea = bus.Write_Data;
    if (bus.RegWrite && bus.Write_Reg != 0 && bus.Write_Reg == bus.Read_Reg2) eb = bus.Write_Data;
`endif
    push(2, {tag, ".a"}, ea);
    push(3, {tag, ".b"}, eb);
    @(posedge Clk);
    if (bus.RegWrite && bus.Write_Reg != 0) mdl[bus.Write_Reg] = bus.Write_Data;
    #1;
    push(0, {tag, ".rd1"}, mrd(bus.Read_Reg1));
    push(1, {tag, ".rd2"}, mrd(bus.Read_Reg2));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    drive(1'b1, 5'd4, 32'h5555_AAAA, 5'd4, 5'd4);
    @(posedge Clk); #1;
    push_all("rst", 32'h0);
    drain();
    @(negedge Clk);
    Reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      cycle("zero_scan");
    end

    // r5 write then a disabled write of a different value
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    cycle("w5");
    push(0, "w5.rd1_const", 32'hDEAD_BEEF); drain();
    drive(1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    cycle("w5_off");
    push(2, "w5.a_const", 32'hDEAD_BEEF); push(1, "w5_off.rd2_const", 32'hDEAD_BEEF); drain();

    // writes to $0 are discarded
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cycle("w0");
    cycle("w0b");
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle("w0c");
    push_all("w0_const", 32'h0); drain();

    // same-edge read/write hazard
    drive(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
    cycle("w7");
    drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd0);
    cycle("haz");
`ifdef REG_FILE_BYPASS_EN
    push(2, "haz.a_const", 32'h2222_2222);
`else
    push(2, "haz.a_const", 32'h1111_1111);
`endif
    push(0, "haz.rd1_const", 32'h2222_2222);
    drain();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    cycle("haz_next");
    push(2, "haz_next.a_const", 32'h2222_2222); drain();

    // both ports on the same index
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd0, 5'd0);
    cycle("w9");
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    cycle("r9");
    cycle("r9b");
    push(2, "r9.a_const", 32'hCAFE_F00D); push(3, "r9.b_const", 32'hCAFE_F00D); drain();

    // fill r1..r31, reading random indices alongside
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'($urandom_range(0, 31)), 5'(i));
      cycle("fill");
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle("rand");
    end
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd31);
    cycle("pre_rst");

    // async reset between edges, with a write presented during reset
    drive(1'b1, 5'd3, 32'hAAAA_5555, 5'd3, 5'd31);
    #2;
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    push_all("async_rst", 32'h0); drain();
    @(posedge Clk); #1;
    push_all("rst_hold", 32'h0); drain();
    #3;
    Reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd12);
    cycle("post_rst");
    push(0, "post_rst.r3_const", 32'h0); drain();

    // first edges after reset perform normal writes
    drive(1'b1, 5'd3, 32'h0BAD_F00D, 5'd3, 5'd3);
    cycle("w3");
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    cycle("r3");
    push(3, "r3.b_const", 32'h0BAD_F00D); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
